// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the LC-3 global datapath bus.
//
// Shares the bus between NREQ drivers (PC, MARMUX, ALU, MDR, ...). One owner at a time
// holds a registered one-hot grant. Ownership ends on the owner's done pulse, when it drops
// its request, or after MAXHOLD consecutive cycles. Every release is followed by one idle
// turnaround cycle before the next grant is issued.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset
//   req        per-requester level-sensitive bus request
//   done       per-requester release pulse (only the current owner's bit is used)
//   grant      registered one-hot grant, zero while the bus is idle
//   sel        registered index of the current or most recent owner (bus mux select)
//   bus_valid  registered, high exactly while grant is non-zero
//   timeout    registered one-cycle pulse when a grant is revoked by MAXHOLD expiry
module bus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SELSIZE = 2,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    grant,
  output logic [SELSIZE-1:0] sel,
  output logic               bus_valid,
  output logic               timeout
);

  localparam int unsigned        HoldW   = $clog2(MAXHOLD + 1);
  localparam logic [HoldW-1:0]   HoldMax = HoldW'(MAXHOLD);
  // Reset pointer at the last index so requester 0 wins the first arbitration.
  localparam logic [SELSIZE-1:0] LastRst = SELSIZE'(NREQ - 1);

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [SELSIZE-1:0] sel_q, sel_d;
  logic [SELSIZE-1:0] last_q, last_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               bus_valid_q, bus_valid_d;
  logic               timeout_q, timeout_d;

  // Round-robin search: scan last+1, last+2, ... modulo NREQ (not modulo 2**SELSIZE),
  // so indices >= NREQ are never visited.
  logic               win_found;
  logic [SELSIZE-1:0] win_idx;
  int unsigned        cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(last_q) + i) % NREQ;
      if (!win_found && (|(req & (NREQ'(1) << cand)))) begin
        win_found = 1'b1;
        win_idx   = SELSIZE'(cand);
      end
    end
  end

  // Owner-side release terms; sel_q always holds the owner index while in StOwn.
  logic own_req;
  logic own_done;
  logic hold_max;
  logic release_own;

  assign own_req     = |(req & (NREQ'(1) << sel_q));
  assign own_done    = |(done & (NREQ'(1) << sel_q));
  assign hold_max    = (hold_cnt_q == HoldMax);
  assign release_own = own_done | ~own_req | hold_max;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (win_found) begin
          state_d    = StOwn;
          grant_d    = NREQ'(1) << win_idx;
          sel_d      = win_idx;
          last_d     = win_idx;
          hold_cnt_d = HoldW'(1);
        end
      end
      StOwn: begin
        if (release_own) begin
          // Dropping to idle for one cycle is the bus turnaround.
          state_d    = StIdle;
          grant_d    = '0;
          hold_cnt_d = '0;
          // Only a pure expiry is flagged; done or a dropped request takes precedence.
          timeout_d  = hold_max & own_req & ~own_done;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        hold_cnt_d = '0;
      end
    endcase

    bus_valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= LastRst;
      hold_cnt_q  <= '0;
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      bus_valid_q <= bus_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = bus_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic, all
// compared against a behavioural owner/pointer model kept in this file.
module tb_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int SELSIZE = 2;
  localparam int MAXHOLD = 8;
  localparam int VW      = NREQ + SELSIZE + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    done = '0;
  logic [NREQ-1:0]    grant;
  logic [SELSIZE-1:0] sel;
  logic               bus_valid;
  logic               timeout;
  logic [VW-1:0]      act;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, who owned it last, how long it has been held.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_held  = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NREQ    (NREQ),
    .SELSIZE (SELSIZE),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  assign act = {grant, sel, bus_valid, timeout};

  function automatic void model_update(logic r, logic [NREQ-1:0] q, logic [NREQ-1:0] d);
    bit expired, o_done, o_req;
    m_to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_last  = NREQ - 1;
      m_held  = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c = (m_last + k) % NREQ;
        if (m_owner < 0 && (|(q & (NREQ'(1) << c)))) begin
          m_owner = c;
          m_sel   = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end else begin
      o_done  = |(d & (NREQ'(1) << m_owner));
      o_req   = |(q & (NREQ'(1) << m_owner));
      expired = (m_held == MAXHOLD);
      if (o_done || !o_req || expired) begin
        m_to    = expired && !o_done && o_req;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] g;
    g = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    return {g, SELSIZE'(m_sel), (m_owner >= 0), m_to};
  endfunction

  // Drive inputs, take one rising edge, advance the model, then settle before sampling.
  task automatic step(input logic r, input logic [NREQ-1:0] q, input logic [NREQ-1:0] d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    model_update(r, q, d);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0);
    step(1'b1, 4'b1111, 4'b1111);
    n_cmp++;
    if (act !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %b want %b", act, exp_vec());
    end
    n_cmp++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: got %b want %b", act, {VW{1'b0}});
    end
  endtask

  task automatic test_single();
    logic [VW-1:0]   seen[5];
    logic [NREQ-1:0] q, d;
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      q = (i < 4) ? 4'b0100 : 4'b0000;
      d = (i == 3) ? 4'b0100 : 4'b0000;
      step(1'b0, q, d);
      seen[i] = act;
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model step %0d: got %b want %b", i, act, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (seen[i] !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_grant cycle %0d: got %b want %b", i, seen[i],
                 {4'b0100, 2'd2, 1'b1, 1'b0});
      end
    end
    n_cmp++;
    if (seen[3] !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: got %b want %b", seen[3], {4'b0000, 2'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_all_req();
    int   order[$];
    int   runs[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    int   run = 0, gap = 0, gaps_bad = 0, n_to = 0;
    logic prev_bv = 1'b0;
    step(1'b1, '0, '0);
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 4'b1111, '0);
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL allreq_model step %0d: got %b want %b", i, act, exp_vec());
      end
      if (bus_valid && !prev_bv) begin
        if (order.size() > 0 && gap != 1) gaps_bad++;
        order.push_back(int'(sel));
        gap = 0;
      end
      if (bus_valid) run++;
      else begin
        if (prev_bv) runs.push_back(run);
        run = 0;
        gap++;
      end
      if (timeout) n_to++;
      prev_bv = bus_valid;
    end
    n_cmp++;
    if (order.size() != 5 || runs.size() != 5) begin
      n_fail++;
      $display("FAIL allreq_count: got %0d grants %0d holds want 5 5", order.size(), runs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (order[i] != exp_order[i] || runs[i] != MAXHOLD) begin
          n_fail++;
          $display("FAIL allreq_grant %0d: got owner %0d held %0d want owner %0d held %0d",
                   i, order[i], runs[i], exp_order[i], MAXHOLD);
        end
      end
    end
    n_cmp++;
    if (gaps_bad != 0 || n_to != 5) begin
      n_fail++;
      $display("FAIL allreq_gap_timeout: got bad_gaps=%0d timeouts=%0d want 0 5", gaps_bad, n_to);
    end
  endtask

  task automatic test_rr_pointer();
    logic [NREQ-1:0] rq[5] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
    logic [NREQ-1:0] dn[5] = '{4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    logic [NREQ-1:0] g[5];
    step(1'b1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, rq[i], dn[i]);
      g[i] = grant;
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL rr_model step %0d: got %b want %b", i, act, exp_vec());
      end
    end
    n_cmp++;
    if (g[2] !== 4'b0001 || g[4] !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_wrap: got %b then %b want 0001 then 1000", g[2], g[4]);
    end
  endtask

  task automatic test_precedence();
    logic [NREQ-1:0] q, d;
    logic [VW-1:0]   seen[18];
    step(1'b1, '0, '0);
    for (int i = 0; i < 18; i++) begin
      q = (i == 17) ? 4'b0000 : 4'b0010;
      d = (i == 8) ? 4'b0010 : ((i == 10) ? 4'b1101 : 4'b0000);
      step(1'b0, q, d);
      seen[i] = act;
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL prec_model step %0d: got %b want %b", i, act, exp_vec());
      end
    end
    n_cmp++;
    if (seen[7] !== {4'b0010, 2'd1, 1'b1, 1'b0} || seen[8] !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prec_done_at_expiry: got %b %b want %b %b", seen[7], seen[8],
               {4'b0010, 2'd1, 1'b1, 1'b0}, {4'b0000, 2'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (seen[10] !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL prec_nonowner_done: got %b want %b", seen[10], {4'b0010, 2'd1, 1'b1, 1'b0});
    end
    n_cmp++;
    if (seen[17] !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prec_drop_at_expiry: got %b want %b", seen[17], {4'b0000, 2'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, '0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, '0);
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_setup: got %b want 0010", grant);
    end
    step(1'b1, 4'b0011, '0);
    n_cmp++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got %b want %b", act, {VW{1'b0}});
    end
    step(1'b0, 4'b0011, '0);
    n_cmp++;
    if (act !== {4'b0001, 2'd0, 1'b1, 1'b0} || act !== exp_vec()) begin
      n_fail++;
      $display("FAIL rstmid_first: got %b want %b", act, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_req_drop();
    step(1'b1, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, '0);
    step(1'b0, 4'b0100, '0);
    n_cmp++;
    if (act !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_release: got %b want %b", act, {4'b0000, 2'd0, 1'b0, 1'b0});
    end
    step(1'b0, 4'b0100, '0);
    n_cmp++;
    if (act !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_next: got %b want %b", act, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    logic               r;
    logic [NREQ-1:0]    q = '0, d;
    logic [SELSIZE-1:0] prev_sel;
    step(1'b1, '0, '0);
    prev_sel = sel;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) q = NREQ'($urandom);
      d = ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : '0;
      r = ($urandom_range(0, 99) == 0);
      step(r, q, d);
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_model step %0d: got %b want %b", i, act, exp_vec());
      end
      n_cmp++;
      if (!$onehot0(grant) || bus_valid !== (|grant) ||
          (bus_valid && grant !== (NREQ'(1) << sel))) begin
        n_fail++;
        $display("FAIL rand_invariant step %0d: got grant=%b sel=%0d valid=%b", i, grant, sel,
                 bus_valid);
      end
      if (!bus_valid && !r) begin
        n_cmp++;
        if (sel !== prev_sel) begin
          n_fail++;
          $display("FAIL rand_sel_stable step %0d: got %0d want %0d", i, sel, prev_sel);
        end
      end
      prev_sel = sel;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_rr_pointer();
    test_precedence();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
